// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-addressed SRAM with a configurable wait-state count.
// A transfer that fails decode, size or alignment checks gets the two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     HDATA_WIDTH = 32,
  parameter int                     MEM_DEPTH   = 1024,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                     WAIT_STATES = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   Hsel,
  input  logic [HADDR_WIDTH-1:0] Haddr,
  input  logic [1:0]             Htrans,
  input  logic                   Hwrite,
  input  logic [2:0]             Hsize,
  input  logic [2:0]             Hburst,
  input  logic [3:0]             Hprot,
  input  logic                   Hmastlock,
  input  logic [HDATA_WIDTH-1:0] Hwdata,
  input  logic                   Hready_in,
  output logic [HDATA_WIDTH-1:0] Hrdata,
  output logic                   Hready_out,
  output logic                   Hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [HADDR_WIDTH:0] MEM_BYTES = (HADDR_WIDTH+1)'(MEM_DEPTH) << 2;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                 state, state_n;
  logic [3:0]             cnt, cnt_n;
  logic                   load;
  logic [OFF_W-1:0]       off_q;
  logic                   wr_q;
  logic [1:0]             size_q;
  logic [HADDR_WIDTH-1:0] off;
  logic                   in_range, misalign, req_err, accept;
  logic [3:0]             lanes;
  logic [IDX_W-1:0]       idx;
  logic [HDATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                   unused;

  assign unused = ^{Hburst, Hprot, Hmastlock, Htrans[0], off[HADDR_WIDTH-1:OFF_W]};

  // Offset from base doubles as the range check and the word index source.
  assign off      = Haddr - BASE_ADDR;
  assign in_range = (Haddr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
  assign misalign = (Hsize == 3'd1 && Haddr[0]) || (Hsize == 3'd2 && Haddr[1:0] != 2'b00);
  assign req_err  = !in_range || (Hsize > 3'd2) || misalign;
  assign accept   = Hsel && Hready_in && Htrans[1];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      S_WAIT: if (cnt == 4'd0) state_n = S_DATA;
              else             cnt_n   = cnt - 4'd1;
      S_ERR1: state_n = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all sample the next address phase
        state_n = S_IDLE;
        if (accept) begin
          load = 1'b1;
          if (req_err)              state_n = S_ERR1;
          else if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = WS_LOAD;
          end
          else                      state_n = S_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      off_q  <= '0;
      wr_q   <= 1'b0;
      size_q <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        off_q  <= off[OFF_W-1:0];
        wr_q   <= Hwrite;
        size_q <= Hsize[1:0];
      end
    end
  end

  assign idx = off_q[OFF_W-1:2];

  always_comb begin
    case (size_q)
      2'd0:    lanes = 4'b0001 << off_q[1:0];
      2'd1:    lanes = off_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (state == S_DATA && wr_q) begin
      for (int b = 0; b < 4; b++)
        if (lanes[b]) mem[idx][8*b +: 8] <= Hwdata[8*b +: 8];
    end
  end

  assign Hrdata     = (state == S_DATA && !wr_q) ? mem[idx] : '0;
  assign Hready_out = !(state == S_WAIT || state == S_ERR1);
  assign Hresp      = (state == S_ERR1) || (state == S_ERR2);

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave memory: the downstream stage that consumes master address/control/write-data and produces Hrdata, Hready_out and Hresp. It serves as the reference DUT behind the master agent. It provides a word-addressed SRAM with a programmable number of wait states, byte/halfword/word writes, and two-cycle ERROR responses. Hmastlock and Hprot are accepted and ignored.

Parameters:
HADDR_WIDTH, 32, address bus width
HDATA_WIDTH, 32, Hwdata/Hrdata width (fixed at 32 for this block)
MEM_DEPTH, 1024, number of 32-bit words; power of 2
BASE_ADDR, 32'h0000_0000, first byte address decoded; aligned to MEM_DEPTH*4
WAIT_STATES, 0, Hready_out-low cycles inserted per OKAY data phase; range 0..15

Ports:
hclk  in  1  clock
hreset  in  1  asynchronous active-high reset
Hsel  in  1  slave select from decoder
Haddr  in  HADDR_WIDTH  byte address
Htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
Hwrite  in  1  1=write
Hsize  in  3  transfer size
Hburst  in  3  burst type (informational, not checked)
Hprot  in  4  ignored
Hmastlock  in  1  ignored
Hwdata  in  HDATA_WIDTH  write data (data phase)
Hready_in  in  1  bus-level ready; previous data phase complete
Hrdata  out  HDATA_WIDTH  read data
Hready_out  out  1  slave ready
Hresp  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (hreset=1, async): Hready_out=1, Hresp=0, Hrdata=0, state IDLE, wait counter 0, pending transfer discarded. Memory contents are not cleared. Reset assertion mid-transfer forces the outputs immediately, without waiting for a clock edge.
- Address-phase accept at posedge: Hsel=1 & Hready_in=1 & Htrans[1]=1. The block latches addr, write, size and a valid flag.
- Error check at accept:
  - Haddr outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4-1] -> error.
  - Hsize>2 -> error.
  - Misaligned address (halfword with Haddr[0]=1, word with Haddr[1:0]!=0) -> error.
- IDLE/BUSY or Hsel=0 with Hready_in=1: no transfer is taken. The next cycle shows Hready_out=1, Hresp=0 (zero-wait OKAY).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> WAIT on a valid accept with WAIT_STATES>0. The counter loads WAIT_STATES-1.
  - IDLE -> DATA on a valid accept with WAIT_STATES=0.
  - IDLE -> ERR1 on an errored accept.
  - WAIT: Hready_out=0, Hresp=0. Decrement the counter; go to DATA when it reaches 0.
  - DATA: Hready_out=1, Hresp=0; data phase completes this cycle.
  - ERR1: Hready_out=0, Hresp=1. ERR2: Hready_out=1, Hresp=1. ERR2 always follows ERR1; wait states are never inserted on errors.
- Exit from DATA or ERR2: re-evaluate the accept condition in the same edge (pipelined back-to-back), giving IDLE, WAIT, DATA or ERR1.
- Latency: with WAIT_STATES=N, an OKAY data phase occupies N+1 cycles.
- Write: commit at the edge ending DATA (Hready_out=1).
  - Byte lanes: size 0 -> lane Haddr[1:0]; size 1 -> lanes {Haddr[1],0} and +1; size 2 -> all lanes. Little-endian.
  - No memory update on error.
- Read: Hrdata = mem[latched word index] while in DATA with a read latched; otherwise Hrdata=0.
  - The full word is returned regardless of Hsize.
  - A write immediately followed by a read of the same word returns the new data, since the write commits before the read data phase.
- Word index = (latched addr - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits.

Test Plan:
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ read 0x10 -> Hready_out stays 1, Hresp=0, Hrdata=0xDEADBEEF in the read data phase.
- WAIT_STATES=2: read 0x10 -> Hready_out 0,0,1 across the data phase; Hrdata valid only on the third cycle.
- After a word write 0x11223344 to 0x20, byte write 0xAA at 0x22 (Hwdata=0x00AA0000), then read 0x20 -> 0x11AA3344.
- Out-of-range address, write to BASE_ADDR+MEM_DEPTH*4:
  - ERR1 (Hready_out=0, Hresp=1), then ERR2 (Hready_out=1, Hresp=1).
  - Readback of word 0 is unchanged.
- Misaligned halfword at 0x01 -> two-cycle ERROR. Htrans=IDLE or Hsel=0 cycles -> Hready_out=1, Hresp=0, memory unchanged.
- WAIT_STATES=3: assert hreset during the second wait cycle of a write -> Hready_out=1, Hresp=0, Hrdata=0 immediately.
  - Target word is not written.
  - After deassertion, a fresh read completes normally.
